regfile_wb: RTL and testbench

- 32x32 general-purpose register file of the MIPS core.
- Receives the destination triple (address, write enable, data) that the execute stage produces, after it has passed through MEM/WB.
- Supplies the two source operands that the decode stage forwards to the execute stage.
- Contains a post-reset clearing sequencer, so storage infers as plain RAM with no array-wide reset.

---
 rtl/regfile_wb_pkg.sv | 33 +++
 rtl/regfile_wb_if.sv | 48 ++++
 rtl/regfile_wb_rdport.sv | 47 ++++
 rtl/regfile_wb.sv | 150 +++++++++++++++
 tb/tb_regfile_wb.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the MIPS register file slice: register geometry,
// bus types, enable/reset encodings and the clearing-sequencer state encoding.
// Imported by regfile_wb_if, regfile_wb_rdport and regfile_wb.
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

  // Register geometry
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegWidth   = 32;

  typedef logic [RegWidth-1:0]   RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = 5'b0;

  // Control encodings
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

  // Clearing sequencer states
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage : regfile_wb_pkg

// File: rtl/regfile_wb_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_if
// Bundles the write-back write port, the two decode read ports and the
// init-busy stall flag of the register file.
//   master : pipeline side (drives write triple and read requests)
//   slave  : register file side (returns read data and init_busy_o)
// Signals:
//   we_i / waddr_i / wdata_i     write-back destination triple
//   re1_i / raddr1_i / rdata1_o  read port 1
//   re2_i / raddr2_i / rdata2_o  read port 2
//   init_busy_o                  high while the clearing sequencer runs
// -----------------------------------------------------------------------------
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = RegNumLog2,
  parameter int REG_W  = RegWidth
) ();

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [REG_W-1:0]  wdata_i;

  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [REG_W-1:0]  rdata1_o;

  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [REG_W-1:0]  rdata2_o;

  logic              init_busy_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i,
    output re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, init_busy_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i,
    input  re2_i, raddr2_i,
    output rdata1_o, rdata2_o, init_busy_o
  );

endinterface : regfile_wb_if

// File: rtl/regfile_wb_rdport.sv
// -----------------------------------------------------------------------------
// regfile_wb_rdport
// Combinational read mux for one register-file read port.
// Priority: blocked (reset / clearing) -> port disabled -> register 0 ->
// forwarded write-back data -> stored value.
// Ports:
//   blocked   1 while reset is asserted or the clearing sequencer runs
//   re        read enable
//   raddr     read address
//   stored    storage contents at raddr
//   fwd_hit   write-back data targets this port's address this cycle
//   fwd_data  write-back data
//   rdata     read result
// -----------------------------------------------------------------------------
module regfile_wb_rdport
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = RegNumLog2,
  parameter int REG_W  = RegWidth
) (
  input  logic              blocked,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [REG_W-1:0]  stored,
  input  logic              fwd_hit,
  input  logic [REG_W-1:0]  fwd_data,
  output logic [REG_W-1:0]  rdata
);

  // NOTE: rdata is given a value before any branch, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    if (blocked) begin
      rdata = '0;
    end else if (re == ReadDisable) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (fwd_hit) begin
      rdata = fwd_data;
    end else begin
      rdata = stored;
    end
  end

endmodule : regfile_wb_rdport

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// 32x32 general-purpose register file of the MIPS core. Accepts the
// write-back destination triple and serves two combinational read ports to
// the decode stage. After reset a sequencer clears entries 1..REG_NUM-1 one
// per cycle so the storage needs no array-wide reset; init_busy_o stalls
// decode meanwhile. Register 0 is never stored and always reads 0.
// Ports:
//   clk   core clock, rising edge
//   rst   synchronous, active-high reset
//   bus   regfile_wb_if.slave: write triple, two read ports, init_busy_o
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read that hits the register being
//                      written this cycle returns the write data directly.
// -----------------------------------------------------------------------------
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int REG_W   = RegWidth,
  parameter int ADDR_W  = RegNumLog2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);

  localparam logic [ADDR_W-1:0] FirstClrAddr = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr     = ADDR_W'(REG_NUM - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;
  logic              clr_we;
  logic              wr_fire;
  logic              blocked;

  logic [REG_W-1:0]  mem [REG_NUM];
  logic [REG_W-1:0]  stored1, stored2;
  logic              fwd_hit1, fwd_hit2;

  // ---------------------------------------------------------------------------
  // Clearing sequencer: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    clr_we    = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + FirstClrAddr;
        // The last entry is cleared on this edge; leave before the pointer wraps.
        if (clr_ptr_q == LastAddr) begin
          state_d = RF_RUN;
          busy_d  = 1'b0;
        end
      end
      RF_RUN: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = RF_CLEAR;
        busy_d  = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= FirstClrAddr;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign wr_fire = (state_q == RF_RUN) && (bus.we_i == WriteEnable) &&
                   (bus.waddr_i != NOPRegAddr);

  // NOTE: the array has no reset branch so it maps onto plain RAM; the
  // clearing sequencer zeroes it over the cycles following reset instead.
  always_ff @(posedge clk) begin
    if (rst != RstEnable) begin
      if (clr_we) begin
        mem[clr_ptr_q] <= ZeroWord;
      end else if (wr_fire) begin
        mem[bus.waddr_i] <= bus.wdata_i;
      end
    end
  end

  assign stored1 = mem[bus.raddr1_i];
  assign stored2 = mem[bus.raddr2_i];

  // ---------------------------------------------------------------------------
  // Write-back to decode forwarding
  // ---------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  assign fwd_hit1 = wr_fire && (bus.re1_i == ReadEnable) && (bus.waddr_i == bus.raddr1_i);
  assign fwd_hit2 = wr_fire && (bus.re2_i == ReadEnable) && (bus.waddr_i == bus.raddr2_i);
`else
  // Without forwarding the pipeline resolves the same-cycle hazard elsewhere.
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  assign blocked = (rst == RstEnable) || busy_q;

  regfile_wb_rdport #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_rdport1 (
    .blocked  (blocked),
    .re       (bus.re1_i),
    .raddr    (bus.raddr1_i),
    .stored   (stored1),
    .fwd_hit  (fwd_hit1),
    .fwd_data (bus.wdata_i),
    .rdata    (bus.rdata1_o)
  );

  regfile_wb_rdport #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_rdport2 (
    .blocked  (blocked),
    .re       (bus.re2_i),
    .raddr    (bus.raddr2_i),
    .stored   (stored2),
    .fwd_hit  (fwd_hit2),
    .fwd_data (bus.wdata_i),
    .rdata    (bus.rdata2_o)
  );

  assign bus.init_busy_o = busy_q;

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb
// Directed self-checking bench for regfile_wb. Inputs change and outputs are
// sampled around the falling clock edge, away from the active rising edge.
// Expected values for the same-cycle hazard follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   busy_cycles;

  regfile_wb_if rf_if ();

  regfile_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts falling edges with init_busy_o high, starting at the current one,
  // while checking that read port 1 stays at zero. Bounded.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    #1;
    while (rf_if.init_busy_o === 1'b1 && n < 200) begin
      check(tag, rf_if.rdata1_o, 32'h0);
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    rf_if.we_i    = WriteEnable;
    rf_if.waddr_i = addr;
    rf_if.wdata_i = data;
    @(negedge clk);
    rf_if.we_i    = WriteDisable;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rf_if.we_i     = WriteDisable;
    rf_if.waddr_i  = '0;
    rf_if.wdata_i  = '0;
    rf_if.re1_i    = ReadEnable;
    rf_if.raddr1_i = 5'd7;
    rf_if.re2_i    = ReadDisable;
    rf_if.raddr2_i = '0;

    // ---- Reset clear: rst held for two edges --------------------------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_busy", {31'b0, rf_if.init_busy_o}, 32'h1);
    check("reset_rd1", rf_if.rdata1_o, 32'h0);
    check("reset_rd2", rf_if.rdata2_o, 32'h0);

    // Release reset; attempt a write to r9 throughout CLEAR, which must be ignored.
    rst = 1'b0;
    rf_if.we_i    = WriteEnable;
    rf_if.waddr_i = 5'd9;
    rf_if.wdata_i = 32'h55;
    count_busy("clear_rd7", busy_cycles);
    rf_if.we_i = WriteDisable;
    check("clear_busy_len", 32'(busy_cycles), 32'd31);
    check("run_busy_low", {31'b0, rf_if.init_busy_o}, 32'h0);
    check("run_rd7", rf_if.rdata1_o, 32'h0);
    rf_if.raddr1_i = 5'd9;
    #1;
    check("clear_write_ignored_r9", rf_if.rdata1_o, 32'h0);

    // ---- Basic write / read --------------------------------------------------
    @(negedge clk);
    write_reg(5'd5, 32'h1234_5678);
    rf_if.raddr1_i = 5'd5;
    #1;
    check("rd1_r5", rf_if.rdata1_o, 32'h1234_5678);
    rf_if.re1_i = ReadDisable;
    #1;
    check("rd1_disabled", rf_if.rdata1_o, 32'h0);
    rf_if.re1_i = ReadEnable;

    // ---- Boundary register r31 on port 2 ------------------------------------
    write_reg(5'd31, 32'hDEAD_BEEF);
    rf_if.re2_i    = ReadEnable;
    rf_if.raddr2_i = 5'd31;
    #1;
    check("rd2_r31", rf_if.rdata2_o, 32'hDEAD_BEEF);
    check("rd1_r5_again", rf_if.rdata1_o, 32'h1234_5678);

    // ---- Register zero -------------------------------------------------------
    rf_if.we_i     = WriteEnable;
    rf_if.waddr_i  = 5'd0;
    rf_if.wdata_i  = 32'hFFFF_FFFF;
    rf_if.raddr1_i = 5'd0;
    rf_if.raddr2_i = 5'd0;
    #1;
    check("r0_same_cycle_rd1", rf_if.rdata1_o, 32'h0);
    check("r0_same_cycle_rd2", rf_if.rdata2_o, 32'h0);
    @(negedge clk);
    rf_if.we_i = WriteDisable;
    #1;
    check("r0_rd1", rf_if.rdata1_o, 32'h0);
    check("r0_rd2", rf_if.rdata2_o, 32'h0);

    // ---- Same-cycle write/read hazard ----------------------------------------
    write_reg(5'd3, 32'hA);
    rf_if.we_i     = WriteEnable;
    rf_if.waddr_i  = 5'd3;
    rf_if.wdata_i  = 32'hB;
    rf_if.raddr1_i = 5'd3;
    rf_if.raddr2_i = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_rd1", rf_if.rdata1_o, 32'hB);
    check("hazard_rd2", rf_if.rdata2_o, 32'hB);
`else
    check("hazard_rd1", rf_if.rdata1_o, 32'hA);
    check("hazard_rd2", rf_if.rdata2_o, 32'hA);
`endif
    @(negedge clk);
    rf_if.we_i = WriteDisable;
    #1;
    check("hazard_next_rd1", rf_if.rdata1_o, 32'hB);
    check("hazard_next_rd2", rf_if.rdata2_o, 32'hB);

    // ---- Reset mid-operation -------------------------------------------------
    write_reg(5'd10, 32'h77);
    rf_if.raddr1_i = 5'd10;
    rf_if.raddr2_i = 5'd5;
    #1;
    check("r10_before_rst", rf_if.rdata1_o, 32'h77);
    rst = 1'b1;
    #1;
    check("rd1_during_rst", rf_if.rdata1_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_busy", {31'b0, rf_if.init_busy_o}, 32'h1);
    count_busy("midop_clear_rd", busy_cycles);
    check("midop_busy_len", 32'(busy_cycles), 32'd31);
    check("r10_cleared", rf_if.rdata1_o, 32'h0);
    check("r5_cleared", rf_if.rdata2_o, 32'h0);

    // ---- Reset again during CLEAR --------------------------------------------
    write_reg(5'd31, 32'h0BAD_F00D);
    rf_if.raddr1_i = 5'd31;
    #1;
    check("r31_before_rst", rf_if.rdata1_o, 32'h0BAD_F00D);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("midclear_busy", {31'b0, rf_if.init_busy_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy("midclear_rd", busy_cycles);
    check("midclear_busy_len", 32'(busy_cycles), 32'd31);
    check("r31_cleared", rf_if.rdata1_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_wb
